// File: rtl/tbuart_pkg.sv
// Shared types and constants for the bench-side 8N1 UART receiver.
`timescale 1ns/1ps
package tbuart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // 40 MHz bench clock / 9600 baud, rounded.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 4167;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; 2 cycles latency, no flow control.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int          WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tbuart_rx.sv
// 8N1 UART receiver with framing-error, end-of-line and good-byte count outputs.
// Strobes land ~half a bit after the stop-bit edge (plus 2 sync cycles); no backpressure, one-cycle strobes.
`timescale 1ns/1ps
module tbuart_rx
    import tbuart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ser_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        eol,
    output logic [15:0] byte_count,
    output logic        busy
);

    localparam logic [15:0] TICK_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TICK_HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (ser_rx),
        .q     (rx_s)
    );

    rx_state_t                   state, state_d;
    logic [15:0]                 tick, tick_d;
    logic [2:0]                  bit_idx, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift, shift_d;
    logic [7:0]                  data_q, data_d;
    logic [15:0]                 count_q, count_d;
    logic                        vld_q, vld_d;
    logic                        ferr_q, ferr_d;
    logic                        eol_q, eol_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            count_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state   <= state_d;
            tick    <= tick_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            data_q  <= data_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            eol_q   <= eol_d;
        end
    end

    always_comb begin
        state_d   = state;
        tick_d    = tick;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        data_d    = data_q;
        count_d   = count_q;
        vld_d     = 1'b0;
        ferr_d    = 1'b0;
        eol_d     = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    tick_d  = TICK_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick != 16'd0) begin
                    tick_d = tick - 16'd1;
                end else if (rx_s) begin
                    // Line went back high before mid start bit: treat as a glitch.
                    state_d = IDLE;
                end else begin
                    tick_d    = TICK_FULL;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick != 16'd0) begin
                    tick_d = tick - 16'd1;
                end else begin
                    shift_d   = {rx_s, shift[UART_DATA_BITS-1:1]};
                    tick_d    = TICK_FULL;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick != 16'd0) begin
                    tick_d = tick - 16'd1;
                end else begin
                    if (rx_s) begin
                        data_d  = shift;
                        vld_d   = 1'b1;
                        eol_d   = (shift == EOL_CHAR);
                        count_d = count_q + 16'd1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data    = data_q;
    assign rx_valid   = vld_q;
    assign frame_err  = ferr_q;
    assign eol        = eol_q;
    assign byte_count = count_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_tbuart_rx.sv
// Directed bench: one receiver at 16 clocks/bit for function tests, three at 4167 for baud and drift.
`timescale 1ns/1ps
module tb_tbuart_rx;

    logic        clock;
    logic        reset;
    logic [3:0]  ser;
    logic [7:0]  rx_data_w    [4];
    logic        rx_valid_w   [4];
    logic        frame_err_w  [4];
    logic        eol_w        [4];
    logic [15:0] byte_count_w [4];
    logic        busy_w       [4];

    int n_checks = 0;
    int n_pass   = 0;

    int         vld_cnt  [4];
    int         ferr_cnt [4];
    logic [7:0] last_dat [4];
    logic [7:0] q0 [$];
    int         eol_cnt;
    int         eol_orphan;
    logic [7:0] eol_dat;
    logic       busy_seen;

    initial clock = 1'b0;
    always #12.5 clock = ~clock;

    tbuart_rx #(
        .CLKS_PER_BIT (16),
        .EOL_CHAR     (8'h0A)
    ) dut0 (
        .clock      (clock),
        .reset      (reset),
        .ser_rx     (ser[0]),
        .rx_data    (rx_data_w[0]),
        .rx_valid   (rx_valid_w[0]),
        .frame_err  (frame_err_w[0]),
        .eol        (eol_w[0]),
        .byte_count (byte_count_w[0]),
        .busy       (busy_w[0])
    );

    for (genvar g = 1; g < 4; g++) begin : g_baud
        tbuart_rx #(
            .CLKS_PER_BIT (4167),
            .EOL_CHAR     (8'h0A)
        ) u_rx (
            .clock      (clock),
            .reset      (reset),
            .ser_rx     (ser[g]),
            .rx_data    (rx_data_w[g]),
            .rx_valid   (rx_valid_w[g]),
            .frame_err  (frame_err_w[g]),
            .eol        (eol_w[g]),
            .byte_count (byte_count_w[g]),
            .busy       (busy_w[g])
        );
    end

    // Strobe capture; every comparison happens in the test tasks.
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid_w[i]) begin
                vld_cnt[i]  = vld_cnt[i] + 1;
                last_dat[i] = rx_data_w[i];
            end
            if (frame_err_w[i]) ferr_cnt[i] = ferr_cnt[i] + 1;
        end
        if (rx_valid_w[0]) q0.push_back(rx_data_w[0]);
        if (eol_w[0]) begin
            eol_cnt = eol_cnt + 1;
            eol_dat = rx_data_w[0];
            if (!rx_valid_w[0]) eol_orphan = eol_orphan + 1;
        end
        if (busy_w[0]) busy_seen = 1'b1;
    end

    task automatic clear_capture();
        for (int i = 0; i < 4; i++) begin
            vld_cnt[i]  = 0;
            ferr_cnt[i] = 0;
        end
        q0.delete();
        eol_cnt    = 0;
        eol_orphan = 0;
        eol_dat    = 8'h00;
        busy_seen  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clear_capture();
    endtask

    task automatic send_frame(input int ln, input logic [7:0] b, input int cpb, input logic stop_bit);
        ser[ln] = 1'b0;
        repeat (cpb) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            ser[ln] = b[i];
            repeat (cpb) @(negedge clock);
        end
        ser[ln] = stop_bit;
        repeat (cpb) @(negedge clock);
        ser[ln] = 1'b1;
    endtask

    task automatic test_reset();
        ser   = 4'hF;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clear_capture();
        n_checks++; if (rx_data_w[0] !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data_w[0]); else n_pass++;
        n_checks++; if (rx_valid_w[0] !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid_w[0]); else n_pass++;
        n_checks++; if (frame_err_w[0] !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err_w[0]); else n_pass++;
        n_checks++; if (eol_w[0] !== 1'b0) $display("FAIL reset_eol: got %b expected 0", eol_w[0]); else n_pass++;
        n_checks++; if (byte_count_w[0] !== 16'h0000) $display("FAIL reset_byte_count: got %h expected 0000", byte_count_w[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_w[0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(0, 8'h55, 16, 1'b1);
        send_frame(0, 8'hA3, 16, 1'b1);
        repeat (32) @(negedge clock);
        n_checks++; if (q0.size() !== 2) $display("FAIL b2b_count: got %0d bytes expected 2", q0.size()); else n_pass++;
        n_checks++; if (q0.size() < 1 || q0[0] !== 8'h55) $display("FAIL b2b_byte0: got %h expected 55", (q0.size() > 0) ? q0[0] : 8'hxx); else n_pass++;
        n_checks++; if (q0.size() < 2 || q0[1] !== 8'hA3) $display("FAIL b2b_byte1: got %h expected a3", (q0.size() > 1) ? q0[1] : 8'hxx); else n_pass++;
        n_checks++; if (byte_count_w[0] !== 16'd2) $display("FAIL b2b_byte_count: got %0d expected 2", byte_count_w[0]); else n_pass++;
        n_checks++; if (ferr_cnt[0] !== 0) $display("FAIL b2b_frame_err: got %0d pulses expected 0", ferr_cnt[0]); else n_pass++;
    endtask

    task automatic test_eol();
        do_reset();
        send_frame(0, 8'h4F, 16, 1'b1);
        send_frame(0, 8'h4B, 16, 1'b1);
        send_frame(0, 8'h0A, 16, 1'b1);
        repeat (32) @(negedge clock);
        n_checks++; if (q0.size() !== 3) $display("FAIL eol_count: got %0d bytes expected 3", q0.size()); else n_pass++;
        n_checks++; if (q0.size() < 3 || q0[0] !== 8'h4F || q0[1] !== 8'h4B || q0[2] !== 8'h0A)
            $display("FAIL eol_bytes: got %0d bytes, first %h expected 4f 4b 0a", q0.size(), (q0.size() > 0) ? q0[0] : 8'hxx);
        else n_pass++;
        n_checks++; if (eol_cnt !== 1) $display("FAIL eol_pulses: got %0d expected 1", eol_cnt); else n_pass++;
        n_checks++; if (eol_dat !== 8'h0A) $display("FAIL eol_data: got %h expected 0a", eol_dat); else n_pass++;
        n_checks++; if (eol_orphan !== 0) $display("FAIL eol_without_valid: got %0d expected 0", eol_orphan); else n_pass++;
        n_checks++; if (byte_count_w[0] !== 16'd3) $display("FAIL eol_byte_count: got %0d expected 3", byte_count_w[0]); else n_pass++;
    endtask

    task automatic test_glitch();
        logic idle_again;
        logic [15:0] cnt_before;
        do_reset();
        send_frame(0, 8'h01, 16, 1'b1);
        repeat (16) @(negedge clock);
        clear_capture();
        cnt_before = byte_count_w[0];
        ser[0] = 1'b0;
        repeat (5) @(negedge clock);
        ser[0] = 1'b1;
        idle_again = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (!busy_w[0]) begin
                idle_again = 1'b1;
                break;
            end
        end
        n_checks++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_rise: got %b expected 1", busy_seen); else n_pass++;
        n_checks++; if (idle_again !== 1'b1) $display("FAIL glitch_busy_timeout: busy still %b after 10 cycles expected 0", busy_w[0]); else n_pass++;
        repeat (200) @(negedge clock);
        n_checks++; if (vld_cnt[0] !== 0 || ferr_cnt[0] !== 0)
            $display("FAIL glitch_strobes: got valid %0d ferr %0d expected 0 0", vld_cnt[0], ferr_cnt[0]);
        else n_pass++;
        n_checks++; if (byte_count_w[0] !== cnt_before) $display("FAIL glitch_byte_count: got %0d expected %0d", byte_count_w[0], cnt_before); else n_pass++;
    endtask

    task automatic test_frame_err();
        do_reset();
        send_frame(0, 8'h5A, 16, 1'b1);
        repeat (16) @(negedge clock);
        send_frame(0, 8'h3C, 16, 1'b0);
        repeat (48) @(negedge clock);
        n_checks++; if (ferr_cnt[0] !== 1) $display("FAIL ferr_pulses: got %0d cycles expected 1", ferr_cnt[0]); else n_pass++;
        n_checks++; if (vld_cnt[0] !== 1) $display("FAIL ferr_valid: got %0d valid pulses expected 1", vld_cnt[0]); else n_pass++;
        n_checks++; if (rx_data_w[0] !== 8'h5A) $display("FAIL ferr_rx_data_hold: got %h expected 5a", rx_data_w[0]); else n_pass++;
        n_checks++; if (byte_count_w[0] !== 16'd1) $display("FAIL ferr_byte_count: got %0d expected 1", byte_count_w[0]); else n_pass++;
        send_frame(0, 8'h11, 16, 1'b1);
        repeat (32) @(negedge clock);
        n_checks++; if (rx_data_w[0] !== 8'h11 || vld_cnt[0] !== 2)
            $display("FAIL ferr_recover: got %h after %0d bytes expected 11 after 2", rx_data_w[0], vld_cnt[0]);
        else n_pass++;
        n_checks++; if (byte_count_w[0] !== 16'd2) $display("FAIL ferr_recover_count: got %0d expected 2", byte_count_w[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int vld_snap;
        do_reset();
        send_frame(0, 8'h21, 16, 1'b1);
        repeat (16) @(negedge clock);
        vld_snap = 0;
        fork
            send_frame(0, 8'hFF, 16, 1'b1);
            begin
                repeat (64) @(negedge clock);
                n_checks++; if (busy_w[0] !== 1'b1) $display("FAIL rmid_busy_before: got %b expected 1", busy_w[0]); else n_pass++;
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL rmid_busy_after: got %b expected 0", busy_w[0]); else n_pass++;
                n_checks++; if (byte_count_w[0] !== 16'd0) $display("FAIL rmid_byte_count: got %0d expected 0", byte_count_w[0]); else n_pass++;
                vld_snap = vld_cnt[0];
            end
        join
        repeat (40) @(negedge clock);
        n_checks++; if (vld_cnt[0] !== vld_snap || ferr_cnt[0] !== 0)
            $display("FAIL rmid_strobes: got %0d extra valid, %0d ferr expected 0 0", vld_cnt[0] - vld_snap, ferr_cnt[0]);
        else n_pass++;
        send_frame(0, 8'h7E, 16, 1'b1);
        repeat (32) @(negedge clock);
        n_checks++; if (rx_data_w[0] !== 8'h7E || byte_count_w[0] !== 16'd1)
            $display("FAIL rmid_next_byte: got %h count %0d expected 7e count 1", rx_data_w[0], byte_count_w[0]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut0.count_q = 16'hFFFF;
        repeat (3) @(negedge clock);
        release dut0.count_q;
        repeat (2) @(negedge clock);
        n_checks++; if (byte_count_w[0] !== 16'hFFFF) $display("FAIL wrap_preload: got %h expected ffff", byte_count_w[0]); else n_pass++;
        send_frame(0, 8'h33, 16, 1'b1);
        repeat (32) @(negedge clock);
        n_checks++; if (byte_count_w[0] !== 16'h0000) $display("FAIL wrap_count: got %h expected 0000", byte_count_w[0]); else n_pass++;
        n_checks++; if (rx_data_w[0] !== 8'h33) $display("FAIL wrap_data: got %h expected 33", rx_data_w[0]); else n_pass++;
    endtask

    task automatic test_baud();
        logic [7:0] exp_dat [4];
        exp_dat[0] = 8'h00;
        exp_dat[1] = 8'h48;
        exp_dat[2] = 8'h5A;
        exp_dat[3] = 8'hC3;
        do_reset();
        fork
            send_frame(1, 8'h48, 4167, 1'b1);
            send_frame(2, 8'h5A, 4250, 1'b1);
            send_frame(3, 8'hC3, 4084, 1'b1);
        join
        repeat (50) @(negedge clock);
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (vld_cnt[i] !== 1) $display("FAIL baud_valid[%0d]: got %0d expected 1", i, vld_cnt[i]); else n_pass++;
            n_checks++; if (last_dat[i] !== exp_dat[i]) $display("FAIL baud_data[%0d]: got %h expected %h", i, last_dat[i], exp_dat[i]); else n_pass++;
            n_checks++; if (ferr_cnt[i] !== 0 || byte_count_w[i] !== 16'd1)
                $display("FAIL baud_status[%0d]: got ferr %0d count %0d expected 0 1", i, ferr_cnt[i], byte_count_w[i]);
            else n_pass++;
        end
    endtask

    initial begin
        ser   = 4'hF;
        reset = 1'b1;
        clear_capture();
        @(negedge clock);
        test_reset();
        test_back_to_back();
        test_eol();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_wrap();
        test_baud();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tbuart_rx.md
Name: tbuart_rx

Overview:
- Synthesizable 8N1 UART receiver that stands in for the bench-side UART monitor on Caravel `mprj_io[6]` (`uart_tx` from the management SoC).
- Deserialises the line into bytes, flags framing errors, and counts received bytes.
- Raises an end-of-line strobe on 0x0A so the surrounding bench or checker logic can compare firmware messages.
- Sits outside the chip, on the same 40 MHz bench clock that drives Caravel.

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per UART bit (40 MHz / 9600 baud, rounded); legal range 4..65535.
- EOL_CHAR, 8'h0A, byte value that raises `eol`.

Ports:
- clock  in  1  bench clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ser_rx  in  1  serial line, idle high; asynchronous to `clock`.
- rx_data  out  8  last received byte, LSB first on the line.
- rx_valid  out  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- eol  out  1  one-cycle strobe, coincident with `rx_valid`, when `rx_data == EOL_CHAR`.
- byte_count  out  16  count of good bytes since reset; wraps 0xFFFF→0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: `rx_data` = 0, all strobes = 0, `byte_count` = 0, `busy` = 0, FSM = IDLE, synchroniser flops = 1.
- Input sync: `ser_rx` passes through a 2-flop synchroniser reset to 1. All decisions use the synchronised value `rx_s`, which adds 2 cycles of latency.
- Bit counter: a 16-bit down-counter `tick`.
- IDLE:
  - On `rx_s == 0`, load `tick` = (CLKS_PER_BIT-1)/2 and go to START.
- START:
  - Decrement `tick`. At 0, resample `rx_s`.
  - If `rx_s == 1` (glitch): return to IDLE; no strobes.
  - Otherwise: load `tick` = CLKS_PER_BIT-1, bit index = 0, go to DATA.
- DATA:
  - At `tick == 0`, shift `rx_s` into shift[7] and right-shift the register, so the first bit ends at bit 0.
  - Reload `tick`, increment the index. After index 7, go to STOP.
  - Sampling is at mid-bit, ±1 cycle.
- STOP:
  - At `tick == 0`, sample `rx_s`.
  - If 1: `rx_data` ← shift, pulse `rx_valid`, pulse `eol` if the byte matches EOL_CHAR, increment `byte_count`.
  - If 0: pulse `frame_err`; `rx_data` and `byte_count` are unchanged.
  - Then go to IDLE in both cases.
- Back-to-back bytes: IDLE can detect the next start bit in the cycle immediately after the strobe. There is no dead time beyond the half-bit reached at the stop-bit sample.
- Break / low line:
  - After a framing error, the FSM returns to IDLE and restarts only on a low level.
  - A line held low therefore gives repeated `frame_err` once per frame time. This is accepted behaviour.
- Strobe timing: all strobes are exactly one cycle wide. `rx_data` holds its value until the next good byte.
- Reset mid-frame: the synchronous reset aborts immediately to IDLE and no strobe is issued. A partial frame after reset release is treated as fresh input; a low level starts a new frame.
- Widths: `tick` is 16 bits, bit index 3 bits, `byte_count` is modulo 2^16.

Decomposition:
- Shared package `tbuart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Constant `UART_DATA_BITS` = 8.
  - Default CLKS_PER_BIT.
- One natural sub-module, `sync_2ff`: generic 2-flop synchroniser with a reset value parameter (1 here).
- The rest stays in one file.

Test Plan (bench uses CLKS_PER_BIT=16 unless noted):
- Send 0x55 then 0xA3, 8N1, back-to-back → two `rx_valid` pulses with `rx_data` 0x55 then 0xA3; `byte_count` = 2; `frame_err` never high.
- Send the ASCII string "OK\n" → `rx_valid` ×3 with bytes 0x4F, 0x4B, 0x0A; `eol` high only with 0x0A; `byte_count` = 3.
- Low pulse of 5 cycles on an idle line → no strobes; FSM back in IDLE (`busy` low) within 10 cycles; `byte_count` unchanged.
- Frame 0x3C with the stop bit forced low → `frame_err` one cycle, no `rx_valid`; `rx_data` keeps its previous value. A following good 0x11 is received correctly.
- Assert `reset` for 1 cycle mid-way through the DATA bits of 0xFF → no strobe; `busy` = 0 the next cycle; `byte_count` = 0; the next clean 0x7E is received.
- Wrap test: preload 65535 good bytes (or force the counter) then send one more → `byte_count` = 0.
- Baud test: CLKS_PER_BIT=4167 at a 25 ns clock, send 0x48 → received correctly.
- Tolerance test: CLKS_PER_BIT=4167 with the transmitter ±2% off → every byte still received correctly.
